// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback write-port arbiter: register-file write request and widths.
package wb_arb_pkg;

    localparam int unsigned XLEN_C = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [XLEN_C-1:0] d;
    } wr_req_t;

endpackage

// File: rtl/wb_wrport_fifo.sv
// Circular pending-write buffer with dual push and single pop.
// WB_WRPORT_ARB_FWD_EN exposes storage and head pointer for forwarding lookups.
module wb_wrport_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push0_i,
    input  wr_req_t                    push0_data_i,
    input  logic                       push1_i,
    input  wr_req_t                    push1_data_i,
    input  logic                       pop_i,
`ifdef WB_WRPORT_ARB_FWD_EN
    output wr_req_t [DEPTH-1:0]        mem_o,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] head_ptr_o,
`endif
    output wr_req_t                    head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wr_req_t [DEPTH-1:0] mem_q;
    logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d, wr1_ptr;
    logic [CntW-1:0]     count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head_d  = pop_i ? ptr_inc(head_q) : head_q;
        // Second push lands behind the first when both are present.
        wr1_ptr = push0_i ? ptr_inc(tail_q) : tail_q;
        tail_d  = tail_q;
        if (push0_i) tail_d = ptr_inc(tail_d);
        if (push1_i) tail_d = ptr_inc(tail_d);
        count_d = count_q + CntW'(push0_i) + CntW'(push1_i) - CntW'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push0_i) mem_q[tail_q] <= push0_data_i;
        if (push1_i) mem_q[wr1_ptr] <= push1_data_i;
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
`ifdef WB_WRPORT_ARB_FWD_EN
    assign mem_o      = mem_q;
    assign head_ptr_o = head_q;
`endif

endmodule

// File: rtl/wb_wrport_arb.sv
// Shares the single rf_xpr write port between writeback lanes wb0 (older) and wb1 (younger).
// Define WB_WRPORT_ARB_FWD_EN to add the pending-write forwarding lookup (fwd_ra/fwd_hit/fwd_data).
module wb_wrport_arb
    import wb_arb_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_C,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       wb0_we,
    input  logic [REG_AW-1:0]          wb0_wa,
    input  logic [XLEN-1:0]            wb0_d,
    input  logic                       wb1_we,
    input  logic [REG_AW-1:0]          wb1_wa,
    input  logic [XLEN-1:0]            wb1_d,
`ifdef WB_WRPORT_ARB_FWD_EN
    input  logic [REG_AW-1:0]          fwd_ra,
    output logic                       fwd_hit,
    output logic [XLEN-1:0]            fwd_data,
`endif
    output logic                       stall,
    output logic [XLEN-1:0]            rf_xpr_wrt0_D,
    output logic [REG_AW-1:0]          rf_xpr_wrt0_WA,
    output logic                       rf_xpr_wrt0_WE,
    output logic [$clog2(DEPTH+1)-1:0] pend_cnt
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wr_req_t         req0, req1, first_req, head_req, push0_data;
    logic            v0, v1, push0, push1, pop, full, empty;
    logic [CntW-1:0] count;

    always_comb begin
        req0 = '{wa: wb0_wa, d: wb0_d};
        req1 = '{wa: wb1_wa, d: wb1_d};
        v0   = !RST && !full && wb0_we && (wb0_wa != '0);
        v1   = !RST && !full && wb1_we && (wb1_wa != '0);
        // Same destination in one pair: the younger lane's write is the only one that matters.
        if (v0 && v1 && (wb0_wa == wb1_wa)) v0 = 1'b0;
        first_req = v0 ? req0 : req1;
    end

    always_comb begin
        rf_xpr_wrt0_WE = 1'b0;
        rf_xpr_wrt0_WA = '0;
        rf_xpr_wrt0_D  = '0;
        if (!RST) begin
            if (!empty) begin
                rf_xpr_wrt0_WE = 1'b1;
                rf_xpr_wrt0_WA = head_req.wa;
                rf_xpr_wrt0_D  = head_req.d;
            end else if (v0 || v1) begin
                rf_xpr_wrt0_WE = 1'b1;
                rf_xpr_wrt0_WA = first_req.wa;
                rf_xpr_wrt0_D  = first_req.d;
            end
        end
    end

    // With an empty queue the first accepted write bypasses, so only the second is enqueued.
    always_comb begin
        pop        = !RST && !empty;
        push0      = empty ? (v0 && v1) : (v0 || v1);
        push0_data = empty ? req1 : first_req;
        push1      = !empty && v0 && v1;
    end

    assign stall    = full;
    assign pend_cnt = count;

`ifdef WB_WRPORT_ARB_FWD_EN
    wr_req_t [DEPTH-1:0] fifo_mem;
    logic [PtrW-1:0]     head_ptr;
    int unsigned         fwd_pos;

    // Scan the not-yet-written stream oldest to youngest; the last match is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_pos  = 0;
        if (!RST && (fwd_ra != '0)) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                fwd_pos = 32'(head_ptr) + i;
                if (fwd_pos >= DEPTH) fwd_pos = fwd_pos - DEPTH;
                if ((i < 32'(count)) && (fifo_mem[fwd_pos[PtrW-1:0]].wa == fwd_ra)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = fifo_mem[fwd_pos[PtrW-1:0]].d;
                end
            end
            if (!empty && v0 && (wb0_wa == fwd_ra)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb0_d;
            end
            if (v1 && (!empty || v0) && (wb1_wa == fwd_ra)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb1_d;
            end
        end
    end
`endif

    wb_wrport_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (CLK),
        .rst_i        (RST),
        .push0_i      (push0),
        .push0_data_i (push0_data),
        .push1_i      (push1),
        .push1_data_i (req1),
        .pop_i        (pop),
`ifdef WB_WRPORT_ARB_FWD_EN
        .mem_o        (fifo_mem),
        .head_ptr_o   (head_ptr),
`endif
        .head_o       (head_req),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty)
    );

endmodule

// File: doc/wb_wrport_arb.md
Name: wb_wrport_arb

Overview:
- Shares the single integer register-file write port (rf_xpr_wrt0) between the two superscalar writeback lanes, wb0 (older) and wb1 (younger).
- A small in-order pending-write queue absorbs dual-issue bursts.
- Back-pressure is applied to both writeback stages when the queue cannot take another pair.
- Sits between the wb0/wb1 stage outputs and the rf_xpr write port.

Parameters:
- XLEN, 32, data width of a register write.
- DEPTH, 2, pending-write queue entries; legal range is 1 or greater.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- wb0_we  in  1  lane-0 (older) write request.
- wb0_wa  in  5  lane-0 destination register.
- wb0_d  in  XLEN  lane-0 write data.
- wb1_we  in  1  lane-1 (younger) write request.
- wb1_wa  in  5  lane-1 destination register.
- wb1_d  in  XLEN  lane-1 write data.
- stall  out  1  hold both writeback stages; inputs are ignored while high.
- rf_xpr_wrt0_D  out  XLEN  register-file write data.
- rf_xpr_wrt0_WA  out  5  register-file write address.
- rf_xpr_wrt0_WE  out  1  register-file write enable.
- pend_cnt  out  $clog2(DEPTH+1)  current queue occupancy (debug/perf).

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous and active-high.
- Reset: queue emptied, count=0, stall=0, WE=0, D=0, WA=0, pend_cnt=0. Reset mid-operation discards all pending writes; no write is issued in the reset cycle.
- Filtering, applied when stall=0:
  - A lane is valid when we=1 and wa!=0. Writes to x0 are dropped.
  - If both lanes are valid and wb0_wa==wb1_wa, wb0 is squashed; the younger write wins.
  - This gives n = 0..2 accepted writes, ordered wb0 then wb1.
- Order: the combined stream is queue contents (oldest first), then the accepted wb0, then the accepted wb1. The register-file write order always equals this program order. No squash is applied against already-queued entries.
- Write port:
  - Each cycle the oldest element of the stream drives D/WA with WE=1.
  - If the queue is empty and n>=1, the first accepted write goes out combinationally in the same cycle (zero-latency bypass).
  - If the stream is empty, WE=0, D=0, WA=0.
- Enqueue: the remaining accepted writes are appended at the tail.
  - count_next = max(count + n - 1, 0).
  - Pointers wrap modulo DEPTH.
- Stall:
  - stall = (count == DEPTH). It is decoded from the registered count only, with no combinational path from the inputs.
  - While stall=1, n is forced to 0, the head still drains, and count drops by 1 per cycle.
  - Invariant: count never exceeds DEPTH; the bench asserts this.
- Boundaries:
  - Full with inputs present: inputs ignored. Upstream must hold them and re-present them after stall falls.
  - Empty with n=2: first write goes out this cycle, second next cycle, stall stays 0.
  - Single valid lane: identical behaviour regardless of which lane carries it.
- Latency: 0 cycles when the queue is empty; otherwise equal to the write's queue position.

Optional Feature:
- Macro: WB_WRPORT_ARB_FWD_EN.
- When defined, added ports:
  - fwd_ra in 5
  - fwd_hit out 1
  - fwd_data out XLEN
- Forwarding rule: fwd_hit=1 when fwd_ra!=0 and matches any element of the stream that is not being written this cycle. fwd_data is the youngest such match. The lookup is purely combinational.
- When undefined: ports absent, no compare logic.

Decomposition:
- Package wb_arb_pkg holds:
  - XLEN_C = 32 and REG_AW = 5.
  - The typedef wr_req_t {wa[4:0], d[XLEN-1:0]}.
- One sub-module, wb_wrport_fifo: a circular buffer of wr_req_t with head/tail/count, push0/push1 (dual-push) and pop, and full/empty.
- Filtering, squash, bypass and stall logic stay in the top level.

Test Plan:
- Single write to empty queue: wb0_we=1, wa=5, d=0xDEADBEEF → same cycle WE=1, WA=5, D=0xDEADBEEF; pend_cnt stays 0.
- Dual write, distinct rd: wb0 (wa=3, d=0x11), wb1 (wa=4, d=0x22) → cycle0 writes x3=0x11; cycle1 writes x4=0x22; pend_cnt=1 for one cycle.
- Same-rd squash: both lanes wa=7, d0=0xAA, d1=0xBB → exactly one write, x7=0xBB; pend_cnt=0.
- x0 drop: wb0 wa=0, wb1 wa=9, d=0x5 → single write x9=0x5; x0 never written.
- Saturation at DEPTH=2: dual writes on 3 consecutive cycles → stall rises when count==2; upstream holds the pair; all 6 writes emerge in program order with no loss and no duplicate.
- Reset mid-drain: count=2, RST=1 for one cycle → WE=0 in that cycle and the next empty cycle, pend_cnt=0, stall=0; with WB_WRPORT_ARB_FWD_EN, fwd_hit=0 for a previously pending rd.
